tx_pio_completion: RTL and testbench

TX_PIO_COMPLETION -- requirements
Module: tx_pio_completion

---
 rtl/tx_pio_completion.sv | 160 ++++++++++++++++
 tb/tb_tx_pio_completion.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pio_completion.sv
// PIO read completer: answers MemRd32 (1 DW) to the NIC BAR with a CplD.
// Ports: RX TRN in, shared TX TRN out (tx_req/tx_grant), drop counter.
module tx_pio_completion #(
  parameter int BAR_IDX     = 2,
  parameter int CPL_TIMEOUT = 255
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] trn_rd,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic [6:0]  trn_rbar_hit_n,
  input  logic [15:0] cfg_completer_id,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic        huge_page_status_1,
  input  logic        huge_page_status_2,
  output logic        tx_req,
  input  logic        tx_grant,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  output logic [7:0]  cpl_drop_cnt
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] REQ  = 3'd2;
  localparam logic [2:0] CPL0 = 3'd3;
  localparam logic [2:0] CPL1 = 3'd4;

  localparam int WW =
    (CPL_TIMEOUT < 2) ? 1 : $clog2(CPL_TIMEOUT + 1);

  logic [2:0]    state;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    tc;
  logic [1:0]    attr;
  logic [15:0]   rid;
  logic [7:0]    tag;
  logic [6:0]    laddr;
  logic [31:0]   rdata;
  logic [31:0]   v_dec;

  logic rx_acc;
  logic rd_qual;
  logic busy_drop;
  logic tmo;
  logic tx_act;
  logic [8:0] drop_sum;

  logic unused_ok;
  assign unused_ok = ^{trn_reof_n, trn_rd};

  assign rx_acc  = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign rd_qual = rx_acc && !trn_rsof_n
                && !trn_rbar_hit_n[BAR_IDX]
                && (trn_rd[62:56] == 7'b00_00000)
                && (trn_rd[41:32] == 10'd1);

  // A new read while the one-deep completer is busy gets no reply.
  assign busy_drop = rd_qual && (state != IDLE);
  assign tmo = (state == REQ) && !tx_grant
            && (wait_cnt == WW'(CPL_TIMEOUT));

  // Both loss sources may fire together, so add rather than OR.
  assign drop_sum = {1'b0, cpl_drop_cnt}
                  + 9'(busy_drop) + 9'(tmo);

  always_comb begin
    v_dec = 32'h0;
    case (trn_rd[39:34])
      6'b010000: v_dec = huge_page_addr_1[31:0];
      6'b010001: v_dec = huge_page_addr_1[63:32];
      6'b010010: v_dec = huge_page_addr_2[31:0];
      6'b010011: v_dec = huge_page_addr_2[63:32];
      6'b011000: v_dec = {31'b0, huge_page_status_1};
      6'b011001: v_dec = {31'b0, huge_page_status_2};
      default:   v_dec = 32'h0;
    endcase
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      tc           <= '0;
      attr         <= '0;
      rid          <= '0;
      tag          <= '0;
      laddr        <= '0;
      rdata        <= '0;
      cpl_drop_cnt <= '0;
    end else begin
      cpl_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        IDLE: begin
          if (rd_qual) begin
            tc    <= trn_rd[54:52];
            attr  <= trn_rd[45:44];
            rid   <= trn_rd[31:16];
            tag   <= trn_rd[15:8];
            state <= HDR;
          end
        end
        HDR: begin
          if (rx_acc && trn_rsof_n) begin
            laddr    <= {trn_rd[38:34], 2'b00};
            rdata    <= v_dec;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (tx_grant) begin
            state <= CPL0;
          end else if (tmo) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CPL0: if (!trn_tdst_rdy_n) state <= CPL1;
        CPL1: if (!trn_tdst_rdy_n) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // TX outputs decode straight off the state register, so they
  // hold while the link stalls and drop at once on reset.
  assign tx_act         = (state == CPL0) || (state == CPL1);
  assign tx_req         = (state == REQ) || tx_act;
  assign trn_tsof_n     = (state != CPL0);
  assign trn_teof_n     = (state != CPL1);
  assign trn_tsrc_rdy_n = !tx_act;
  assign trn_trem_n     = tx_act ? 8'h00 : 8'hFF;

  always_comb begin
    trn_td = 64'h0;
    unique case (1'b1)
      (state == CPL0): trn_td = {
        1'b0, 7'b10_01010, 1'b0, tc, 4'b0,
        1'b0, 1'b0, attr, 2'b0, 10'd1,
        cfg_completer_id, 3'b000, 1'b0, 12'd4};
      (state == CPL1): trn_td = {
        rid, tag, 1'b0, laddr,
        rdata[7:0], rdata[15:8],
        rdata[23:16], rdata[31:24]};
      default: trn_td = 64'h0;
    endcase
  end

endmodule

// File: tb/tb_tx_pio_completion.sv
// Directed bench for tx_pio_completion.
// Drives RX reads, checks CplD beats, drops, timeout and reset.
module tb_tx_pio_completion;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] trn_rd = '0;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rdst_rdy_n = 1'b0;
  logic [6:0]  trn_rbar_hit_n = 7'h7F;
  logic [15:0] cfg_completer_id = 16'hABCD;
  logic [63:0] huge_page_addr_1 = 64'h1122334455667788;
  logic [63:0] huge_page_addr_2 = 64'h99AABBCCDDEEFF00;
  logic        huge_page_status_1 = 1'b0;
  logic        huge_page_status_2 = 1'b1;
  logic        tx_req;
  logic        tx_grant = 1'b0;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n = 1'b0;
  logic [7:0]  cpl_drop_cnt;

  int total = 0;
  int bad = 0;
  int beats = 0;
  int b_snap;

  localparam logic [6:0] BAR2 = 7'b1111011;
  localparam logic [6:0] BAR0 = 7'b1111110;
  localparam logic [63:0] CPL0_EXP = 64'h4A000001_ABCD0004;

  tx_pio_completion dut (
    .trn_clk(trn_clk),
    .reset_n(reset_n),
    .trn_rd(trn_rd),
    .trn_rsof_n(trn_rsof_n),
    .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .trn_rbar_hit_n(trn_rbar_hit_n),
    .cfg_completer_id(cfg_completer_id),
    .huge_page_addr_1(huge_page_addr_1),
    .huge_page_addr_2(huge_page_addr_2),
    .huge_page_status_1(huge_page_status_1),
    .huge_page_status_2(huge_page_status_2),
    .tx_req(tx_req),
    .tx_grant(tx_grant),
    .trn_td(trn_td),
    .trn_trem_n(trn_trem_n),
    .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .cpl_drop_cnt(cpl_drop_cnt)
  );

  always #5 trn_clk = ~trn_clk;

  always @(posedge trn_clk)
    if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) beats++;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge trn_clk);
      #1;
    end
  endtask

  task automatic chk(input string tg,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tg, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_b0(
    input logic [6:0] ft, input logic [9:0] len,
    input logic [2:0] tc, input logic [1:0] attr,
    input logic [15:0] rid, input logic [7:0] tag);
    return {1'b0, ft, 1'b0, tc, 4'b0, 2'b0, attr,
            2'b0, len, rid, tag, 8'h0F};
  endfunction

  task automatic send(input logic [63:0] h0,
                      input logic [31:0] addr,
                      input logic [6:0] bar);
    trn_rd = h0;
    trn_rsof_n = 1'b0;
    trn_rbar_hit_n = bar;
    trn_rsrc_rdy_n = 1'b0;
    step();
    trn_rd = {addr, 32'h0};
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b0;
    step();
    trn_rsrc_rdy_n = 1'b1;
    trn_reof_n = 1'b1;
    trn_rbar_hit_n = 7'h7F;
  endtask

  task automatic run_cpl(input string tg,
                         input logic [63:0] e0,
                         input logic [63:0] e1);
    b_snap = beats;
    tx_grant = 1'b1;
    step();
    tx_grant = 1'b0;
    chk({tg, "_td0"}, trn_td, e0);
    chk({tg, "_sof"}, 64'(trn_tsof_n), 64'd0);
    step();
    chk({tg, "_td1"}, trn_td, e1);
    chk({tg, "_eof"}, 64'(trn_teof_n), 64'd0);
    step();
    chk({tg, "_idle"}, 64'(tx_req), 64'd0);
    chk({tg, "_beats"}, 64'(beats - b_snap), 64'd2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #2;
    chk("rst_req", 64'(tx_req), 64'd0);
    chk("rst_sof", 64'(trn_tsof_n), 64'd1);
    chk("rst_eof", 64'(trn_teof_n), 64'd1);
    chk("rst_src", 64'(trn_tsrc_rdy_n), 64'd1);
    chk("rst_rem", 64'(trn_trem_n), 64'hFF);
    chk("rst_td", trn_td, 64'd0);
    chk("rst_drop", 64'(cpl_drop_cnt), 64'd0);
    #1;
    reset_n = 1'b1;
    step();

    // basic read of 0x40
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h05),
         32'h40, BAR2);
    chk("r1_req_lat", 64'(tx_req), 64'd1);
    chk("r1_src_req", 64'(trn_tsrc_rdy_n), 64'd1);
    tx_grant = 1'b1;
    step();
    tx_grant = 1'b0;
    chk("r1_td0", trn_td, CPL0_EXP);
    chk("r1_sof", 64'(trn_tsof_n), 64'd0);
    chk("r1_src", 64'(trn_tsrc_rdy_n), 64'd0);
    chk("r1_rem", 64'(trn_trem_n), 64'h00);
    step();
    chk("r1_td1", trn_td, 64'h01000540_88776655);
    chk("r1_eof", 64'(trn_teof_n), 64'd0);
    chk("r1_sof1", 64'(trn_tsof_n), 64'd1);
    step();
    chk("r1_idle", 64'(tx_req), 64'd0);
    chk("r1_srcidle", 64'(trn_tsrc_rdy_n), 64'd1);

    // status_2 readback with non-zero TC/attr
    send(mk_b0(7'h00, 10'd1, 3'd5, 2'd2, 16'h0200, 8'h07),
         32'h64, BAR2);
    run_cpl("r64", 64'h4A502001_ABCD0004,
            64'h02000764_01000000);

    // unmapped offset reads zero
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h09),
         32'h70, BAR2);
    run_cpl("r70", CPL0_EXP, 64'h01000970_00000000);

    // non-qualifying requests
    send(mk_b0(7'h00, 10'd2, 3'd0, 2'd0, 16'h0100, 8'h01),
         32'h40, BAR2);
    chk("nq_len2", 64'(tx_req), 64'd0);
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h02),
         32'h40, BAR0);
    chk("nq_bar0", 64'(tx_req), 64'd0);
    send(mk_b0(7'h20, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h03),
         32'h0, BAR2);
    step();
    chk("nq_mrd64", 64'(tx_req), 64'd0);
    chk("nq_drop", 64'(cpl_drop_cnt), 64'd0);

    // TX stall in CPL0
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h22),
         32'h40, BAR2);
    b_snap = beats;
    trn_tdst_rdy_n = 1'b1;
    tx_grant = 1'b1;
    step();
    tx_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("st_td0", trn_td, CPL0_EXP);
      chk("st_sof", 64'(trn_tsof_n), 64'd0);
      if (i < 2) step();
    end
    trn_tdst_rdy_n = 1'b0;
    step();
    chk("st_td1", trn_td, 64'h01002240_88776655);
    step();
    chk("st_beats", 64'(beats - b_snap), 64'd2);
    chk("st_idle", 64'(tx_req), 64'd0);

    // second read while waiting for grant
    do_reset();
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h11),
         32'h40, BAR2);
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0300, 8'h12),
         32'h44, BAR2);
    chk("bz_drop", 64'(cpl_drop_cnt), 64'd1);
    chk("bz_req", 64'(tx_req), 64'd1);
    run_cpl("bz", CPL0_EXP, 64'h01001140_88776655);
    step(3);
    chk("bz_nomore", 64'(tx_req), 64'd0);

    // grant timeout
    do_reset();
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h33),
         32'h40, BAR2);
    step(255);
    chk("to_wait", 64'(tx_req), 64'd1);
    chk("to_drop0", 64'(cpl_drop_cnt), 64'd0);
    step();
    chk("to_idle", 64'(tx_req), 64'd0);
    chk("to_drop", 64'(cpl_drop_cnt), 64'd1);

    // reset during CPL1
    send(mk_b0(7'h00, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h44),
         32'h40, BAR2);
    tx_grant = 1'b1;
    step();
    tx_grant = 1'b0;
    step();
    chk("ar_cpl1", 64'(trn_teof_n), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("ar_req", 64'(tx_req), 64'd0);
    chk("ar_eof", 64'(trn_teof_n), 64'd1);
    chk("ar_src", 64'(trn_tsrc_rdy_n), 64'd1);
    chk("ar_rem", 64'(trn_trem_n), 64'hFF);
    chk("ar_td", trn_td, 64'd0);
    chk("ar_drop", 64'(cpl_drop_cnt), 64'd0);
    #2;
    reset_n = 1'b1;
    b_snap = beats;
    step(3);
    chk("ar_nobeat", 64'(beats - b_snap), 64'd0);
    chk("ar_idle", 64'(tx_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
